conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_win_pkg.sv | 19 +
 rtl/conv_win_line_mem.sv | 26 ++
 rtl/conv_window_gen.sv | 170 +++++++++++++++++
 tb/tb_conv_window_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/conv_win_pkg.sv
// Shared types and sizing helpers for the sliding-window generator.
// Zero padding is enabled by defining CONV_WIN_ZERO_PAD_EN.
package conv_win_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [0:0] {
    ST_SCAN  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Number of window positions along one axis (floor division).
  function automatic int out_dim(input int in_size, input int k, input int s, input int p);
    return (in_size + p + p - k) / s + 32'sd1;
  endfunction

endpackage

// File: rtl/conv_win_line_mem.sv
// One row of pixel history: asynchronous read, synchronous write, no reset.
module conv_win_line_mem #(
  parameter int WIDTH  = 24,
  parameter int DEPTH  = 34,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // The old row is visible on rdata during the cycle it gets overwritten.
  assign rdata = mem_r[addr];

  // Row storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// KxK sliding-window generator over a raster pixel stream with optional zero
// padding (compiled in only when CONV_WIN_ZERO_PAD_EN is defined).
module conv_window_gen
  import conv_win_pkg::*;
#(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 8,
  parameter int NFMAPS   = 3,
  parameter int STRIDE   = 1,
  parameter int PAD      = 1,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [NFMAPS*BITWIDTH-1:0]               in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [NFMAPS*KER_SIZE*KER_SIZE*BITWIDTH-1:0] out_window,
  output logic                                     out_last
);

`ifdef CONV_WIN_ZERO_PAD_EN
  localparam int PE = PAD;
`else
  localparam int PE = 0;
`endif
  localparam int K      = KER_SIZE;
  localparam int GW     = IMG_W + PE + PE;
  localparam int GH     = IMG_H + PE + PE;
  localparam int PW     = NFMAPS * BITWIDTH;
  localparam int XW     = $clog2(GW);
  localparam int YW     = $clog2(GH);
  localparam int OW     = out_dim(IMG_W, K, STRIDE, PE);
  localparam int OH     = out_dim(IMG_H, K, STRIDE, PE);
  localparam int LAST_X = K - 1 + (OW - 1) * STRIDE;
  localparam int LAST_Y = K - 1 + (OH - 1) * STRIDE;

  if (KER_SIZE < 32'sd2 || KER_SIZE > 32'sd7 || STRIDE < 32'sd1 || STRIDE > 32'sd4 ||
      PAD < 32'sd0 || PAD > KER_SIZE - 32'sd1) begin : g_bad_cfg
    $error("conv_window_gen: illegal KER_SIZE/STRIDE/PAD combination");
  end

  state_t              state_r;
  logic                active_r;
  logic [XW-1:0]       px_r;
  logic [YW-1:0]       py_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic [BITWIDTH-1:0] win_r [NFMAPS][K][K];

  logic          is_pad_s, slot_free_s, advance_s, emit_s, last_win_s, frame_end_s;
  logic [PW-1:0] pix_s;
  logic [PW-1:0] rd_s  [K-1];
  logic [PW-1:0] col_s [K];

  // Position classification for the current scan point
  always_comb begin
    is_pad_s = 1'b0;
`ifdef CONV_WIN_ZERO_PAD_EN
    if (int'(px_r) < PE || int'(px_r) >= PE + IMG_W ||
        int'(py_r) < PE || int'(py_r) >= PE + IMG_H) begin
      is_pad_s = 1'b1;
    end else begin
      is_pad_s = 1'b0;
    end
`endif
    slot_free_s = !out_valid_r || out_ready;
    advance_s   = (state_r == ST_SCAN) && active_r && (is_pad_s || in_valid) && slot_free_s;
    emit_s      = (int'(px_r) >= K - 1) && (int'(py_r) >= K - 1) &&
                  ((int'(px_r) - (K - 1)) % STRIDE == 32'sd0) &&
                  ((int'(py_r) - (K - 1)) % STRIDE == 32'sd0);
    last_win_s  = (int'(px_r) == LAST_X) && (int'(py_r) == LAST_Y);
    frame_end_s = (int'(px_r) == GW - 1) && (int'(py_r) == GH - 1);
    pix_s       = is_pad_s ? {PW{1'b0}} : in_data;
  end

  assign in_ready = (state_r == ST_SCAN) && active_r && !is_pad_s && slot_free_s;

  // New window column: oldest row from the deepest line memory, newest row live.
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_s[r] = rd_s[K - 2 - r];
    end
    col_s[K-1] = pix_s;
  end

  for (genvar j = 0; j < K - 1; j++) begin : g_line
    logic [PW-1:0] wdata_s;
    if (j == 32'sd0) begin : g_first
      assign wdata_s = pix_s;
    end else begin : g_chain
      assign wdata_s = rd_s[j-1];
    end
    conv_win_line_mem #(.WIDTH(PW), .DEPTH(GW), .ADDR_W(XW)) u_mem (
      .clk   (clk),
      .we    (advance_s),
      .addr  (px_r),
      .wdata (wdata_s),
      .rdata (rd_s[j])
    );
  end

  // Scan FSM, window shift register and output handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_SCAN;
      active_r    <= 1'b0;
      px_r        <= '0;
      py_r        <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      for (int f = 0; f < NFMAPS; f++)
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            win_r[f][r][c] <= '0;
    end else begin
      active_r <= 1'b1;
      case (state_r)
        ST_SCAN: begin
          if (advance_s) begin
            for (int f = 0; f < NFMAPS; f++)
              for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++)
                  win_r[f][r][c] <= win_r[f][r][c+1];
                win_r[f][r][K-1] <= col_s[r][f*BITWIDTH +: BITWIDTH];
              end
            out_valid_r <= emit_s;
            out_last_r  <= emit_s && last_win_s;
            if (frame_end_s) begin
              state_r <= ST_DRAIN;
              px_r    <= '0;
              py_r    <= '0;
            end else if (int'(px_r) == GW - 1) begin
              px_r <= '0;
              py_r <= py_r + 1'b1;
            end else begin
              px_r <= px_r + 1'b1;
            end
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (slot_free_s) begin
            state_r     <= ST_SCAN;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        end
        default: state_r <= ST_SCAN;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

  for (genvar f = 0; f < NFMAPS; f++) begin : g_pf
    for (genvar r = 0; r < K; r++) begin : g_pr
      for (genvar c = 0; c < K; c++) begin : g_pc
        assign out_window[((f*K + r)*K + c)*BITWIDTH +: BITWIDTH] = win_r[f][r][c];
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench: two 3x3 generators (stride 1 with pad, stride 2 without pad)
// checked against a direct window model and hand-computed windows.
module tb_conv_window_gen;
  import conv_win_pkg::*;

  localparam int K  = 3;
  localparam int NF = 3;
  localparam int BW = 8;
  localparam int WW = NF * K * K * BW;

`ifdef CONV_WIN_ZERO_PAD_EN
  localparam int PA     = 1;
  localparam int NWIN_A = 16;
  localparam logic [71:0] FIRST_A = {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
`else
  localparam int PA     = 0;
  localparam int NWIN_A = 4;
  localparam logic [71:0] FIRST_A = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
`endif

  logic          clk, rstn;
  logic [NF*BW-1:0] in_data;
  logic          in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic          in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [WW-1:0] out_window_a, out_window_b;
  bit            sel;
  logic          in_ready_m, out_valid_m, out_last_m;
  logic [WW-1:0] out_window_m;
  int            checks, errors;
  int            orig_b [4];

  assign in_ready_m   = sel ? in_ready_b   : in_ready_a;
  assign out_valid_m  = sel ? out_valid_b  : out_valid_a;
  assign out_last_m   = sel ? out_last_b   : out_last_a;
  assign out_window_m = sel ? out_window_b : out_window_a;

  conv_window_gen #(.KER_SIZE(3), .BITWIDTH(8), .NFMAPS(3), .STRIDE(1), .PAD(1),
                    .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_window(out_window_a), .out_last(out_last_a));

  conv_window_gen #(.KER_SIZE(3), .BITWIDTH(8), .NFMAPS(3), .STRIDE(2), .PAD(0),
                    .IMG_W(5), .IMG_H(5)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_window(out_window_b), .out_last(out_last_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map f of pixel idx (1-based) is idx+32*f; a negated frame lands in 128..255.
  function automatic pixel_t pix_val(input int idx, input int f, input bit neg);
    pixel_t v;
    v = pixel_t'(idx + 32 * f);
    if (neg) v = pixel_t'(-int'(v));
    return v;
  endfunction

  // Window n taken straight from the padded image definition.
  function automatic logic [WW-1:0] exp_win(input bit s, input bit neg, input int n);
    int st, p, w, ow, wx, wy, x, y;
    logic [WW-1:0] e;
    e  = '0;
    st = s ? 2 : 1;
    p  = s ? 0 : PA;
    w  = s ? 5 : 4;
    ow = (w + 2 * p - K) / st + 1;
    wx = n % ow;
    wy = n / ow;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) begin
          x = wx * st + c - p;
          y = wy * st + r - p;
          if (x >= 0 && x < w && y >= 0 && y < w)
            e[((f*K + r)*K + c)*BW +: BW] = pix_val(y * w + x + 1, f, neg);
        end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, out_valid_m, '0);
    chk({tag, "_out_last"}, out_last_m, '0);
    chk({tag, "_out_window"}, out_window_m, '0);
    chk({tag, "_in_ready"}, in_ready_m, '0);
  endtask

  // Stream one frame into the selected instance and check every window.
  task automatic run_frame(input bit s, input bit neg, input int stall_win, input int abort_after);
    int pix, win, cyc, hold, nwin, npix, gaps, bad;
    logic [WW-1:0] held;
    bit rdy, vld;
    nwin = s ? 4 : NWIN_A;
    npix = s ? 25 : 16;
    pix = 0; win = 0; cyc = 0; hold = 0; gaps = 0;
    held = '0;
    sel = s;
    while (win < nwin && cyc < 2000 && (abort_after < 0 || pix < abort_after)) begin
      @(negedge clk);
      cyc++;
      rdy = !(out_valid_m && win == stall_win && hold < 10);
      vld = (pix < npix);
      in_data = {pix_val(pix + 1, 2, neg), pix_val(pix + 1, 1, neg), pix_val(pix + 1, 0, neg)};
      if (s) begin out_ready_b = rdy; in_valid_b = vld; end
      else   begin out_ready_a = rdy; in_valid_a = vld; end
      #1;
      if (!rdy) begin
        if (hold == 0) held = out_window_m;
        else chk("hold_window", out_window_m, held);
        chk("hold_in_ready", in_ready_m, '0);
        hold++;
      end
      if (vld && !in_ready_m && pix > 0) gaps++;
      if (vld && in_ready_m) pix++;
      if (out_valid_m && rdy) begin
        chk($sformatf("win%0d_s%0d_n%0d", win, s, neg), out_window_m, exp_win(s, neg, win));
        chk($sformatf("last%0d", win), out_last_m, (win == nwin - 1));
        if (win == 0 && !s && !neg) chk("first_a_map0", out_window_m[71:0], FIRST_A);
        if (s) chk($sformatf("origin_b%0d", win), out_window_m[7:0], orig_b[win]);
        if (neg) begin
          bad = 0;
          for (int i = 0; i < NF * K * K; i++)
            if (out_window_m[i*BW +: BW] != 8'd0 && !out_window_m[i*BW + BW - 1]) bad++;
          chk("no_prev_frame_value", bad, '0);
        end
        win++;
      end
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    if (abort_after < 0) begin
      chk("timeout", (cyc < 2000), 1);
      chk("window_count", win, nwin);
      chk("beat_count", pix, npix);
      if (s) chk("in_ready_gaps", gaps, '0);
      if (stall_win >= 0) chk("stall_cycles", hold, 10);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    orig_b[0] = 1; orig_b[1] = 3; orig_b[2] = 11; orig_b[3] = 13;
    sel = 1'b0; rstn = 1'b0; in_data = '0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready_a = 1'b1; out_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    sel = 1'b0; #1; chk_reset("rst_a");
    sel = 1'b1; #1; chk_reset("rst_b");
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(1'b0, 1'b0, -1, -1);
    run_frame(1'b1, 1'b0, -1, -1);
    run_frame(1'b0, 1'b0, 2, -1);
    repeat (5) @(negedge clk);
    #1; chk("no_extra_valid", out_valid_a, '0);

    run_frame(1'b0, 1'b0, -1, 7);
    @(negedge clk); rstn = 1'b0;
    #1; sel = 1'b0; #1; chk_reset("midframe_rst");
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(1'b0, 1'b0, -1, -1);

    run_frame(1'b0, 1'b0, -1, -1);
    run_frame(1'b0, 1'b1, -1, -1);
    repeat (5) @(negedge clk);
    #1; chk("no_extra_valid_end", out_valid_a, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
